// File: rtl/saxil_read_arb.sv
// Two-requester AXI-Lite read arbiter onto one slave; round-robin, one read in flight; AR handshake T -> m_rvalid T+3 at zero slave wait.
// arready only in IDLE (other requesters wait); slave stalls hold ADDR/DATA; master rready low holds RESP.
module saxil_read_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              saxil_read_arb_clk,
  input  logic              saxil_read_arb_rst_n,
  input  logic              saxil_read_arb_m0_arvalid,
  output logic              saxil_read_arb_m0_arready,
  input  logic [ADDR_W-1:0] saxil_read_arb_m0_araddr,
  input  logic [2:0]        saxil_read_arb_m0_arprot,
  output logic              saxil_read_arb_m0_rvalid,
  input  logic              saxil_read_arb_m0_rready,
  output logic [DATA_W-1:0] saxil_read_arb_m0_rdata,
  output logic [1:0]        saxil_read_arb_m0_rresp,
  input  logic              saxil_read_arb_m1_arvalid,
  output logic              saxil_read_arb_m1_arready,
  input  logic [ADDR_W-1:0] saxil_read_arb_m1_araddr,
  input  logic [2:0]        saxil_read_arb_m1_arprot,
  output logic              saxil_read_arb_m1_rvalid,
  input  logic              saxil_read_arb_m1_rready,
  output logic [DATA_W-1:0] saxil_read_arb_m1_rdata,
  output logic [1:0]        saxil_read_arb_m1_rresp,
  output logic              saxil_read_arb_s_arvalid,
  output logic [ADDR_W-1:0] saxil_read_arb_s_araddr,
  output logic [2:0]        saxil_read_arb_s_arprot,
  input  logic              saxil_read_arb_s_arready,
  input  logic              saxil_read_arb_s_rvalid,
  input  logic [DATA_W-1:0] saxil_read_arb_s_rdata,
  input  logic [1:0]        saxil_read_arb_s_rresp,
  output logic              saxil_read_arb_s_rready,
  output logic [1:0]        saxil_read_arb_grant
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_last;
  logic [1:0]        r_grant;
  logic [ADDR_W-1:0] r_araddr;
  logic [2:0]        r_arprot;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic              r_s_arvalid;
  logic              r_s_rready;
  logic [1:0]        r_m_rvalid;

  logic [1:0] w_req;
  logic [1:0] w_pick;
  logic       w_arb;
  logic       w_rdone;

  assign w_req = {saxil_read_arb_m1_arvalid, saxil_read_arb_m0_arvalid};

  // r_last names the requester served most recently; a tie goes to the other one.
  always_comb begin
    w_pick = 2'b00;
    if (w_req == 2'b11) begin
      w_pick = r_last ? 2'b01 : 2'b10;
    end else begin
      w_pick = w_req;
    end
  end

  // Reset gates the combinational arready so nothing is accepted while held in reset.
  assign w_arb   = (r_state == S_IDLE) && saxil_read_arb_rst_n;
  assign w_rdone = (r_state == S_RESP) &&
                   (|(r_grant & {saxil_read_arb_m1_rready, saxil_read_arb_m0_rready}));

  assign saxil_read_arb_m0_arready = w_arb & w_pick[0];
  assign saxil_read_arb_m1_arready = w_arb & w_pick[1];

  assign saxil_read_arb_s_arvalid = r_s_arvalid;
  assign saxil_read_arb_s_araddr  = r_araddr;
  assign saxil_read_arb_s_arprot  = r_arprot;
  assign saxil_read_arb_s_rready  = r_s_rready;
  assign saxil_read_arb_grant     = r_grant;

  assign saxil_read_arb_m0_rvalid = r_m_rvalid[0];
  assign saxil_read_arb_m1_rvalid = r_m_rvalid[1];
  assign saxil_read_arb_m0_rdata  = r_rdata;
  assign saxil_read_arb_m1_rdata  = r_rdata;
  assign saxil_read_arb_m0_rresp  = r_rresp;
  assign saxil_read_arb_m1_rresp  = r_rresp;

  always_ff @(posedge saxil_read_arb_clk or negedge saxil_read_arb_rst_n) begin
    if (!saxil_read_arb_rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_grant     <= 2'b00;
      r_araddr    <= '0;
      r_arprot    <= '0;
      r_rdata     <= '0;
      r_rresp     <= '0;
      r_s_arvalid <= 1'b0;
      r_s_rready  <= 1'b0;
      r_m_rvalid  <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_pick) begin
            r_grant     <= w_pick;
            r_araddr    <= w_pick[1] ? saxil_read_arb_m1_araddr : saxil_read_arb_m0_araddr;
            r_arprot    <= w_pick[1] ? saxil_read_arb_m1_arprot : saxil_read_arb_m0_arprot;
            r_s_arvalid <= 1'b1;
            r_state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (saxil_read_arb_s_arready) begin
            r_s_arvalid <= 1'b0;
            r_s_rready  <= 1'b1;
            r_state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (saxil_read_arb_s_rvalid) begin
            r_rdata    <= saxil_read_arb_s_rdata;
            r_rresp    <= saxil_read_arb_s_rresp;
            r_s_rready <= 1'b0;
            r_m_rvalid <= r_grant;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_rdone) begin
            r_m_rvalid <= 2'b00;
            r_last     <= r_grant[1];
            r_grant    <= 2'b00;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_saxil_read_arb.sv
// Directed bench for saxil_read_arb: negedge monitor plus parameterised slave, hand-computed expectations.
module tb_saxil_read_arb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk, rst_n;
  logic [1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0] m_araddr [2];
  logic [2:0]    m_arprot [2];
  logic [DW-1:0] m_rdata  [2];
  logic [1:0]    m_rresp  [2];
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AW-1:0] s_araddr;
  logic [2:0]    s_arprot;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic [1:0]    grant;

  int errors = 0;
  int checks = 0;

  saxil_read_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .saxil_read_arb_clk       (clk),
    .saxil_read_arb_rst_n     (rst_n),
    .saxil_read_arb_m0_arvalid(m_arvalid[0]),
    .saxil_read_arb_m0_arready(m_arready[0]),
    .saxil_read_arb_m0_araddr (m_araddr[0]),
    .saxil_read_arb_m0_arprot (m_arprot[0]),
    .saxil_read_arb_m0_rvalid (m_rvalid[0]),
    .saxil_read_arb_m0_rready (m_rready[0]),
    .saxil_read_arb_m0_rdata  (m_rdata[0]),
    .saxil_read_arb_m0_rresp  (m_rresp[0]),
    .saxil_read_arb_m1_arvalid(m_arvalid[1]),
    .saxil_read_arb_m1_arready(m_arready[1]),
    .saxil_read_arb_m1_araddr (m_araddr[1]),
    .saxil_read_arb_m1_arprot (m_arprot[1]),
    .saxil_read_arb_m1_rvalid (m_rvalid[1]),
    .saxil_read_arb_m1_rready (m_rready[1]),
    .saxil_read_arb_m1_rdata  (m_rdata[1]),
    .saxil_read_arb_m1_rresp  (m_rresp[1]),
    .saxil_read_arb_s_arvalid (s_arvalid),
    .saxil_read_arb_s_araddr  (s_araddr),
    .saxil_read_arb_s_arprot  (s_arprot),
    .saxil_read_arb_s_arready (s_arready),
    .saxil_read_arb_s_rvalid  (s_rvalid),
    .saxil_read_arb_s_rdata   (s_rdata),
    .saxil_read_arb_s_rresp   (s_rresp),
    .saxil_read_arb_s_rready  (s_rready),
    .saxil_read_arb_grant     (grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state, updated once per negedge.
  int            ar_cyc [2], rv_cyc [2], rhs_cyc [2], rcnt [2];
  logic [1:0]    grant_at_rv [2];
  logic [DW-1:0] got_rdata [2];
  logic [1:0]    got_rresp [2];
  int            unstable, sr_cyc;
  logic [AW-1:0] sa_addr;
  logic [2:0]    sa_prot;
  int            gnt_q [$];
  int            gcyc_q [$];

  // Slave behaviour knobs.
  bit            slave_en;
  int            ar_wait, r_wait;
  logic [DW-1:0] slv_rdata;
  logic [1:0]    slv_rresp;

  initial begin
    logic [1:0]    prv_rv;
    logic [DW-1:0] prv_rdata [2];
    logic [1:0]    prv_rresp [2];
    logic          prv_sarv;
    logic [AW-1:0] prv_saddr;
    logic [2:0]    prv_sprot;
    int            ar_cnt, r_cnt;
    prv_rv = 2'b00; prv_sarv = 1'b0; prv_saddr = '0; prv_sprot = '0;
    ar_cnt = 0; r_cnt = 0; unstable = 0; sr_cyc = 0;
    sa_addr = '0; sa_prot = '0;
    for (int i = 0; i < 2; i++) begin
      ar_cyc[i] = 0; rv_cyc[i] = 0; rhs_cyc[i] = 0; rcnt[i] = 0;
      grant_at_rv[i] = 2'b00; got_rdata[i] = '0; got_rresp[i] = '0;
      prv_rdata[i] = '0; prv_rresp[i] = '0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prv_rv   = 2'b00;
        prv_sarv = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (m_arvalid[i] && m_arready[i]) begin
            ar_cyc[i] = cyc;
            gnt_q.push_back(i);
            gcyc_q.push_back(cyc);
          end
          if (m_rvalid[i] && !prv_rv[i]) begin
            rv_cyc[i]      = cyc;
            grant_at_rv[i] = grant;
          end
          if (prv_rv[i] && m_rvalid[i] && (m_rdata[i] !== prv_rdata[i] || m_rresp[i] !== prv_rresp[i]))
            unstable++;
          if (prv_rv[i] && !m_rvalid[i] && !m_rready[i])
            unstable++;
          if (m_rvalid[i] && m_rready[i]) begin
            rhs_cyc[i]   = cyc;
            rcnt[i]++;
            got_rdata[i] = m_rdata[i];
            got_rresp[i] = m_rresp[i];
          end
          prv_rv[i]    = m_rvalid[i];
          prv_rdata[i] = m_rdata[i];
          prv_rresp[i] = m_rresp[i];
        end
        if (prv_sarv && s_arvalid && (s_araddr !== prv_saddr || s_arprot !== prv_sprot))
          unstable++;
        if (prv_sarv && !s_arvalid && !s_arready)
          unstable++;
        prv_sarv  = s_arvalid;
        prv_saddr = s_araddr;
        prv_sprot = s_arprot;
      end
      if (slave_en) begin
        if (s_arvalid && !s_arready) begin
          if (ar_cnt >= ar_wait) s_arready = 1'b1;
          else ar_cnt++;
        end else begin
          s_arready = 1'b0;
          ar_cnt    = 0;
        end
        if (s_rready && !s_rvalid) begin
          if (r_cnt >= r_wait) begin
            s_rvalid = 1'b1;
            s_rdata  = slv_rdata;
            s_rresp  = slv_rresp;
          end else begin
            r_cnt++;
          end
        end else begin
          s_rvalid = 1'b0;
          r_cnt    = 0;
        end
      end
      // These values are the ones present at the coming posedge.
      if (rst_n && s_arvalid && s_arready) begin
        sa_addr = s_araddr;
        sa_prot = s_arprot;
      end
      if (rst_n && s_rvalid && s_rready) sr_cyc = cyc;
    end
  end

  task automatic issue(input int m, input logic [AW-1:0] a, input logic [2:0] p);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    m_arvalid[m] = 1'b1;
    m_araddr[m]  = a;
    m_arprot[m]  = p;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (m_arready[m]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    m_arvalid[m] = 1'b0;
    chk("ar_handshake", ok, 1'b1);
  endtask

  task automatic wait_rsp(input int m);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (m_rvalid[m] && m_rready[m]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    chk("r_handshake", ok, 1'b1);
  endtask

  initial begin
    int rel, bad, seen0, r0, r1;
    logic ok;
    rst_n = 1'b0;
    m_arvalid = 2'b01; m_rready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      m_araddr[i] = '0;
      m_arprot[i] = '0;
    end
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
    slave_en = 1'b1; ar_wait = 0; r_wait = 0; slv_rdata = '0; slv_rresp = '0;

    // Reset state, with a request pending that must not be accepted.
    @(negedge clk);
    chk("rst_arready",  m_arready, 2'b00);
    chk("rst_rvalid",   m_rvalid, 2'b00);
    chk("rst_s_arvalid", s_arvalid, 1'b0);
    chk("rst_s_rready", s_rready, 1'b0);
    chk("rst_grant",    grant, 2'b00);
    chk("rst_s_araddr", s_araddr, 32'h0);
    chk("rst_rdata",    m_rdata[0], 32'h0);
    @(posedge clk); #1;
    m_arvalid = 2'b00;
    rst_n = 1'b1;

    // Single m0 read, zero-wait slave.
    slv_rdata = 32'hDEAD_BEEF; slv_rresp = 2'b00;
    issue(0, 32'h0000_0010, 3'b010);
    wait_rsp(0);
    chk("m0_latency",   rv_cyc[0] - ar_cyc[0], 3);
    chk("m0_rdata",     got_rdata[0], 32'hDEAD_BEEF);
    chk("m0_rresp",     got_rresp[0], 2'b00);
    chk("m0_s_araddr",  sa_addr, 32'h0000_0010);
    chk("m0_s_arprot",  sa_prot, 3'b010);
    chk("m0_grant",     grant_at_rv[0], 2'b01);
    chk("m1_untouched", rcnt[1], 0);
    chk("idle_grant",   grant, 2'b00);

    // Both requesting from the first edge after reset release.
    @(posedge clk); #1;
    rst_n = 1'b0;
    m_arvalid = 2'b11;
    m_araddr[0] = 32'h100; m_araddr[1] = 32'h104;
    slv_rdata = 32'h5555_AAAA;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel = cyc;
    gnt_q.delete(); gcyc_q.delete();
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (gnt_q.size() >= 4) break;
    end
    m_arvalid = 2'b00;
    wait_rsp(1);
    chk("rr_count", gnt_q.size(), 4);
    if (gnt_q.size() >= 4) begin
      chk("rr_g0", gnt_q[0], 0);
      chk("rr_g1", gnt_q[1], 1);
      chk("rr_g2", gnt_q[2], 0);
      chk("rr_g3", gnt_q[3], 1);
      chk("first_arb_cycle", gcyc_q[0], rel);
      chk("b2b_gap", gcyc_q[1] - gcyc_q[0], 4);
    end

    // Slave stalls: arready 3 cycles late, rvalid 2 cycles late.
    ar_wait = 3; r_wait = 2; slv_rdata = 32'hCAFE_0001; slv_rresp = 2'b00;
    issue(0, 32'h0000_1234, 3'b001);
    wait_rsp(0);
    chk("stall_stable",  unstable, 0);
    chk("stall_s_araddr", sa_addr, 32'h0000_1234);
    chk("stall_r_lat",   rv_cyc[0] - sr_cyc, 1);
    chk("stall_total",   rv_cyc[0] - ar_cyc[0], 8);
    chk("stall_rdata",   got_rdata[0], 32'hCAFE_0001);
    ar_wait = 0; r_wait = 0;

    // m1 holds rready low in RESP while m0 requests.
    m_rready[1] = 1'b0;
    slv_rdata = 32'h1111_2222;
    issue(1, 32'h0000_0200, 3'b000);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (m_rvalid[1]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("m1_resp_seen", ok, 1'b1);
    @(posedge clk); #1;
    m_arvalid[0] = 1'b1; m_araddr[0] = 32'h300;
    seen0 = 0; bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_arready[0]) seen0++;
      if (!m_rvalid[1]) bad++;
    end
    @(posedge clk); #1;
    m_rready[1] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (m_arready[0]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    m_arvalid[0] = 1'b0;
    chk("hold_arready0", seen0, 0);
    chk("hold_rvalid1",  bad, 0);
    chk("hold_m0_grant", ok, 1'b1);
    chk("hold_m1_rdata", got_rdata[1], 32'h1111_2222);
    chk("hold_next_arb", ar_cyc[0], rhs_cyc[1] + 1);
    wait_rsp(0);

    // Error responses forwarded untouched.
    r0 = rcnt[0];
    slv_rdata = 32'h0BAD_F00D; slv_rresp = 2'b10;
    issue(1, 32'h0000_0FFC, 3'b000);
    wait_rsp(1);
    chk("slverr_rresp",  got_rresp[1], 2'b10);
    chk("slverr_rdata",  got_rdata[1], 32'h0BAD_F00D);
    chk("slverr_addr",   sa_addr, 32'h0000_0FFC);
    chk("slverr_m0_quiet", rcnt[0], r0);
    slv_rdata = 32'h0000_0077; slv_rresp = 2'b11;
    issue(0, 32'h0000_0008, 3'b000);
    wait_rsp(0);
    chk("decerr_rresp", got_rresp[0], 2'b11);

    // Reset asserted while waiting in DATA.
    r_wait = 50; slv_rresp = 2'b00;
    issue(0, 32'h0000_0040, 3'b000);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (s_rready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_in_data", ok, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_s_rready",  s_rready, 1'b0);
    chk("mid_s_arvalid", s_arvalid, 1'b0);
    chk("mid_grant",     grant, 2'b00);
    chk("mid_rvalid",    m_rvalid, 2'b00);
    slave_en = 1'b0; r_wait = 0;
    r0 = rcnt[0]; r1 = rcnt[1];
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_rvalid = 1'b1; s_rdata = 32'hBAD0_BAD0; s_rresp = 2'b00;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (s_rready || m_rvalid != 2'b00 || grant != 2'b00) bad++;
    end
    @(posedge clk); #1;
    s_rvalid = 1'b0;
    chk("late_rvalid_ignored", bad, 0);
    chk("late_no_rsp", rcnt[0] + rcnt[1], r0 + r1);
    slave_en = 1'b1;
    gnt_q.delete();
    m_arvalid = 2'b11;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (gnt_q.size() > 0) break;
    end
    m_arvalid = 2'b00;
    chk("post_rst_grant_seen", gnt_q.size(), 1);
    if (gnt_q.size() > 0) chk("post_rst_tie_m0", gnt_q[0], 0);
    wait_rsp(0);
    chk("final_stable", unstable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
